// File: rtl/corefifo_pkg.sv
// Shared constants and elaboration helpers for the FIFO controller front-end stages.
package corefifo_pkg;

  localparam logic [1:0] Q_DEPTH = 2'd2;

  function automatic bit pack_legal(input int p);
    return (p == 1) || (p == 2) || (p == 4);
  endfunction

  // Lane index width; never below one bit so PACK=1 still has a counter.
  function automatic int lane_w(input int p);
    int w;
    w = 1;
    while ((1 << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/corefifo_wr_queue.sv
// Two-entry queue of packed words sitting between the lane packer and the FIFO controller.
module corefifo_wr_queue
  import corefifo_pkg::*;
#(
  parameter int FWIDTH = 10
) (
  input  logic              wr_clk,
  input  logic              reset_wclk,
  input  logic              push,
  input  logic              pop,
  input  logic [FWIDTH-1:0] push_data,
  output logic [FWIDTH-1:0] head,
  output logic [1:0]        q_cnt,
  output logic [1:0]        q_cnt_next
);

  logic [FWIDTH-1:0] mem0;
  logic [FWIDTH-1:0] mem1;

  always_comb begin
    q_cnt_next = q_cnt;
    if (push && !pop && (q_cnt != Q_DEPTH))
      q_cnt_next = q_cnt + 2'd1;
    else if (pop && !push && (q_cnt != 2'd0))
      q_cnt_next = q_cnt - 2'd1;
  end

  always_ff @(posedge wr_clk) begin
    if (reset_wclk)
      q_cnt <= 2'd0;
    else
      q_cnt <= q_cnt_next;
  end

  // mem0 is always the head; entries shift down on a pop.
  always_ff @(posedge wr_clk) begin
    if (pop) begin
      mem0 <= (push && (q_cnt == 2'd1)) ? push_data : mem1;
      if (push && (q_cnt == Q_DEPTH))
        mem1 <= push_data;
    end else if (push) begin
      if (q_cnt == 2'd0)
        mem0 <= push_data;
      else if (q_cnt == 2'd1)
        mem1 <= push_data;
    end
  end

  assign head = mem0;

endmodule

// File: rtl/corefifo_wr_stage.sv
// Write-side front end: packs PACK producer words into one FIFO word, buffers two
// packed words and forwards them to the controller while it is not full.
module corefifo_wr_stage
  import corefifo_pkg::*;
#(
  parameter int WWIDTH    = 10,
  parameter int PACK      = 1,
  parameter int WRITE_LOW = 1
) (
  input  logic                   wr_clk,
  input  logic                   reset_wclk,
  input  logic                   wr_en,
  input  logic [WWIDTH-1:0]      din,
  input  logic                   flush,
  input  logic                   fifo_full,
  output logic                   wr_ready,
  output logic                   fifo_wr_en,
  output logic [WWIDTH*PACK-1:0] fifo_din,
  output logic                   wr_ack,
  output logic                   overflow,
  output logic                   idle
);

  localparam int FWIDTH = WWIDTH * PACK;
  localparam int LW     = lane_w(PACK);
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);

  if (!pack_legal(PACK)) begin : g_pack_chk
    $error("corefifo_wr_stage: PACK must be 1, 2 or 4");
  end

  logic              we_p;
  logic              accept;
  logic              pop;
  logic              push;
  logic              flush_go;
  logic [LW-1:0]     lane_cnt;
  logic [LW-1:0]     lane_cnt_next;
  logic [FWIDTH-1:0] pack_q;
  logic [FWIDTH-1:0] pack_next;
  logic [FWIDTH-1:0] lane_data;
  logic [FWIDTH-1:0] push_data;
  logic [1:0]        q_cnt;
  logic [1:0]        q_cnt_next;

  assign we_p       = (WRITE_LOW != 0) ? ~wr_en : wr_en;
  assign accept     = we_p & wr_ready;
  assign fifo_wr_en = (q_cnt != 2'd0) & ~fifo_full & ~reset_wclk;
  assign pop        = fifo_wr_en;
  assign flush_go   = flush & ~accept & (lane_cnt != '0) & ((q_cnt < Q_DEPTH) | pop);
  assign idle       = (lane_cnt == '0) & (q_cnt == 2'd0);

  // The pack register is cleared after every push, so a flushed partial word
  // already carries zeros in its unfilled lanes.
  always_comb begin
    lane_data = pack_q;
    lane_data[int'(lane_cnt)*WWIDTH +: WWIDTH] = din;
    push          = 1'b0;
    push_data     = pack_q;
    pack_next     = pack_q;
    lane_cnt_next = lane_cnt;
    if (accept) begin
      if (lane_cnt == LAST_LANE) begin
        push          = 1'b1;
        push_data     = lane_data;
        pack_next     = '0;
        lane_cnt_next = '0;
      end else begin
        pack_next     = lane_data;
        lane_cnt_next = lane_cnt + 1'b1;
      end
    end else if (flush_go) begin
      push          = 1'b1;
      pack_next     = '0;
      lane_cnt_next = '0;
    end
  end

  // Ready only drops when the next accept would complete a pack with no free slot.
  always_ff @(posedge wr_clk) begin
    if (reset_wclk) begin
      lane_cnt <= '0;
      pack_q   <= '0;
      wr_ready <= 1'b0;
      wr_ack   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      lane_cnt <= lane_cnt_next;
      pack_q   <= pack_next;
      wr_ready <= (q_cnt_next < Q_DEPTH) | (lane_cnt_next != LAST_LANE);
      wr_ack   <= accept;
      overflow <= overflow | (we_p & ~wr_ready);
    end
  end

  corefifo_wr_queue #(
    .FWIDTH (FWIDTH)
  ) u_queue (
    .wr_clk     (wr_clk),
    .reset_wclk (reset_wclk),
    .push       (push),
    .pop        (pop),
    .push_data  (push_data),
    .head       (fifo_din),
    .q_cnt      (q_cnt),
    .q_cnt_next (q_cnt_next)
  );

endmodule

// File: doc/corefifo_wr_stage.md
# corefifo_wr_stage

Write-side front end for the FIFO controller, mirroring the read-side FWFT stage. It accepts producer words under a registered `wr_ready` handshake and packs `PACK` consecutive words into one FIFO-width word. It buffers up to two packed words and issues `fifo_wr_en`/`fifo_din` to the controller only when the controller is not full. It also reports overflow and can flush a partially packed word.

## Interface
- `WWIDTH`, 10: producer word width.
- `PACK`, 1: producer words per FIFO word; legal values 1, 2, 4. Derived `FWIDTH = WWIDTH*PACK`.
- `WRITE_LOW`, 1: 1 means `wr_en` is active-low.

Ports:
- `wr_clk` in 1: the single clock; all logic is posedge `wr_clk`.
- `reset_wclk` in 1: reset; synchronous, active-high.
- `wr_en` in 1: producer write request; polarity set by `WRITE_LOW`. Internally `we_p`.
- `din` in WWIDTH: producer data.
- `flush` in 1: level request to push a partial pack.
- `fifo_full` in 1: controller full.
- `wr_ready` out 1: registered; acceptance guaranteed this cycle.
- `fifo_wr_en` out 1: write strobe to the controller, active-high.
- `fifo_din` out FWIDTH: packed word to the controller.
- `wr_ack` out 1: registered pulse, one per accepted word.
- `overflow` out 1: sticky; `we_p` seen while `wr_ready`=0.
- `idle` out 1: lane count 0 and queue empty.

## Operation
- A word is accepted when `we_p & wr_ready`. It is written into lane `lane_cnt` of the pack register; lane 0 occupies bits [WWIDTH-1:0].
- When the lane that completes the pack (`PACK-1`) is written, the full word is pushed to the queue tail and `lane_cnt` returns to 0. For `PACK`=1 every accepted word is pushed.
- The queue is 2 entries with `q_cnt` in 0..2.
  - `fifo_wr_en = (q_cnt != 0) & !fifo_full & !reset_wclk`.
  - `fifo_din` is the queue head.
  - A pop happens on a cycle with `fifo_wr_en`=1.
  - Push and pop in the same cycle leave `q_cnt` unchanged.
- `wr_ready` is registered: `wr_ready <= (q_cnt_next < 2) | (lane_cnt_next != PACK-1)`.
  - This is conservative and never accepts a word without a home.
  - `q_cnt` can only shrink without an acceptance, so a high `wr_ready` is always honored.
- Flush:
  - Flush acts only in a cycle with no acceptance, `lane_cnt` > 0, and `q_cnt` < 2 (or a pop this cycle).
  - It pushes the pack register with unfilled lanes forced to 0, then sets `lane_cnt` to 0.
  - When acceptance and flush coincide, the accept wins and flush stays pending as a level.
  - Flush with `lane_cnt` = 0 is a no-op.
- `overflow` sets on `we_p & !wr_ready` and clears only on reset. The rejected word is dropped.
- `wr_ack` is high in the cycle after each acceptance.

## Timing
- Reset (any cycle, including mid-packet) clears everything:
  - `q_cnt`=0, `lane_cnt`=0, pack register 0.
  - `wr_ready`=0, `wr_ack`=0, `overflow`=0.
  - `fifo_wr_en`=0 combinationally while reset is high, `idle`=1.
  - Held data is discarded.
- First edge with reset low: `wr_ready` rises.
- Latency for `PACK`=1: word accepted at edge N is the head from N+1, so `fifo_wr_en` is high in cycle N+1 if `!fifo_full`.
- Latency for `PACK`=k: the packed word appears the cycle after the k-th accept.
- Sustained throughput is one producer word per cycle with `fifo_full`=0.
- Full boundary:
  - With `fifo_full` high and `PACK`=1, exactly 2 words are accepted.
  - `wr_ready` falls the cycle after the 2nd accept.
  - `wr_ready` rises the cycle after the first pop.
- With `PACK`>1 and the queue full, `PACK-1` further words are accepted into lanes before `wr_ready` falls.

## Structure
- Package `corefifo_pkg`:
  - `PACK` legality check.
  - `clog2`-style lane-width function.
  - `Q_DEPTH=2` constant.
- Sub-module `corefifo_wr_queue`: 2-entry FIFO-width queue with push/pop/`q_cnt`, head output, synchronous reset.
- The top level contains the lane packer, flush, ready, ack and overflow logic. Target 150–300 lines total.

## Test plan
- **Reset:** `PACK`=1, `WRITE_LOW`=1; after reset, `wr_en`=0 with `din`=0x155, `fifo_full`=0.
  - `fifo_wr_en`=1 the next cycle with `fifo_din`=0x155.
  - `wr_ack` pulses once; `idle` returns to 1.
- **Full backpressure:** `PACK`=1, `fifo_full`=1, 4 back-to-back writes 1,2,3,4.
  - Only 1 and 2 are accepted; `wr_ready`=0 afterwards.
  - `overflow`=1 after a further `we_p`.
  - Releasing `fifo_full` gives writes of 1, then 2, in order.
- **Packing:** `PACK`=4, words 0x001..0x004.
  - One `fifo_wr_en` with `fifo_din` = {0x004, 0x003, 0x002, 0x001}, one cycle after the 4th accept.
- **Flush:** `PACK`=4, words 0x0AA and 0x0BB, then `flush`=1.
  - `fifo_din` = {0, 0, 0x0BB, 0x0AA}; `lane_cnt`=0.
  - A flush with `lane_cnt`=0 produces no write.
- **Reset mid-operation:** `PACK`=2, queue full, one lane filled; assert `reset_wclk` for one cycle.
  - No `fifo_wr_en` afterwards; all outputs at reset values.
  - The next two accepted words form a fresh pack.
- **Random stress:** random `we_p`, `fifo_full` and `flush`.
  - Scoreboard checks order, no loss on accepted words, and `q_cnt` ≤ 2.
